// File: rtl/apb_slave_array_pkg.sv
// Shared types and constants for the APB slave array behind the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int ADDR_LSB     = 2;
  localparam int LOCAL_ADDR_W = 12;
  localparam int MAX_SLAVES   = 32;

  // Select vectors are zero-extended to MAX_SLAVES so one helper serves any NUM_SLAVES.
  function automatic logic onehot_ok(input logic [MAX_SLAVES-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/apb_slave_array_if.sv
// APB bus between the bridge (master) and the slave array (slave).
interface apb_slave_array_if #(
  parameter int NUM_SLAVES = 3
);
  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [31:0]           Paddr;
  logic [31:0]           Pwdata;
  logic [31:0]           Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_array_regfile.sv
// One slave's word storage: single write port, combinational read at the same index.
module apb_slave_regfile #(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_slave_array.sv
// APB slave array: SETUP/ACCESS sequencing, wait states, error responses and
// NUM_SLAVES register files selected by one-hot Pselx.
//   state  | meaning
//   IDLE   | waiting for a SETUP cycle (Pselx set, Penable low)
//   ACCESS | transfer latched; counting wait states, completes when cnt==0
module apb_slave_array
  import apb_bridge_pkg::*;
#(
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  apb_slave_array_if.slave     apb,
  output logic [ERR_CNT_W-1:0] Perr_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = LOCAL_ADDR_W - ADDR_LSB;

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  setup;
  logic                  setup_err;
  logic                  pready;
  logic                  commit;
  logic [NUM_SLAVES-1:0] we;
  logic [31:0]           rdata [NUM_SLAVES];
  logic [31:0]           rd_mux;
  logic [OFF_W-1:0]      off;
  logic                  unused_addr;

  // Upper address bits are region decode, owned by the bridge.
  assign unused_addr = ^apb.Paddr[31:LOCAL_ADDR_W];

  assign off       = apb.Paddr[LOCAL_ADDR_W-1:ADDR_LSB];
  assign setup     = (state_q == IDLE) && (|apb.Pselx) && !apb.Penable;
  assign setup_err = !onehot_ok(MAX_SLAVES'(apb.Pselx))
                     || (apb.Paddr[ADDR_LSB-1:0] != '0)
                     || ({1'b0, off} >= (OFF_W+1)'(DEPTH));
  assign pready    = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          sel_d   = apb.Pselx;
          idx_d   = apb.Paddr[ADDR_LSB +: IDX_W];
          write_d = apb.Pwrite;
          wdata_d = apb.Pwdata;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if ((apb.Pselx == '0) || !apb.Penable) begin
          state_d = IDLE;
        end else if (pready) begin
          state_d = IDLE;
          commit  = 1'b1;
          if (err_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    we = '0;
    if (commit && write_q && !err_q) we = sel_q;
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
    apb_slave_regfile #(.DEPTH(DEPTH)) u_rf (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .we      (we[g]),
      .idx     (idx_q),
      .wdata   (wdata_q),
      .rdata   (rdata[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q[i]) rd_mux = rd_mux | rdata[i];
  end

  assign apb.Pready  = pready;
  assign apb.Pslverr = pready && err_q;
  assign apb.Prdata  = (pready && !err_q && !write_q) ? rd_mux : 32'h0;
  assign Perr_cnt    = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_array.sv
// Directed and randomized APB transfers against three slave-array configurations.
module tb_apb_slave_array;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  always #5 Hclk = ~Hclk;

  apb_slave_array_if #(.NUM_SLAVES(3)) if0 ();
  apb_slave_array_if #(.NUM_SLAVES(3)) if1 ();
  apb_slave_array_if #(.NUM_SLAVES(3)) if2 ();
  logic [7:0] e0, e1;
  logic [1:0] e2;

  apb_slave_array #(.NUM_SLAVES(3), .DEPTH(16), .WAIT_STATES(0), .ERR_CNT_W(8)) u0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(if0.slave), .Perr_cnt(e0));
  apb_slave_array #(.NUM_SLAVES(3), .DEPTH(16), .WAIT_STATES(3), .ERR_CNT_W(8)) u1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(if1.slave), .Perr_cnt(e1));
  apb_slave_array #(.NUM_SLAVES(3), .DEPTH(16), .WAIT_STATES(2), .ERR_CNT_W(2)) u2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(if2.slave), .Perr_cnt(e2));

  int          cur = 0;
  logic [2:0]  t_sel = '0;
  logic        t_en = 1'b0, t_wr = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;

  assign if0.Pselx = (cur == 0) ? t_sel : 3'b000;
  assign if1.Pselx = (cur == 1) ? t_sel : 3'b000;
  assign if2.Pselx = (cur == 2) ? t_sel : 3'b000;
  assign if0.Penable = (cur == 0) && t_en;
  assign if1.Penable = (cur == 1) && t_en;
  assign if2.Penable = (cur == 2) && t_en;
  assign if0.Pwrite = t_wr;   assign if1.Pwrite = t_wr;   assign if2.Pwrite = t_wr;
  assign if0.Paddr  = t_addr; assign if1.Paddr  = t_addr; assign if2.Paddr  = t_addr;
  assign if0.Pwdata = t_wdata; assign if1.Pwdata = t_wdata; assign if2.Pwdata = t_wdata;

  logic [31:0] o_rdata, o_ecnt;
  logic        o_ready, o_slverr;
  always_comb begin
    o_rdata = if0.Prdata; o_ready = if0.Pready; o_slverr = if0.Pslverr; o_ecnt = 32'(e0);
    if (cur == 1) begin
      o_rdata = if1.Prdata; o_ready = if1.Pready; o_slverr = if1.Pslverr; o_ecnt = 32'(e1);
    end else if (cur == 2) begin
      o_rdata = if2.Prdata; o_ready = if2.Pready; o_slverr = if2.Pslverr; o_ecnt = 32'(e2);
    end
  end

  // Reference model: storage per instance/slave/word, error counts, per-instance limits.
  logic [31:0] mem [3][3][16];
  int          ecnt [3];
  int          ws   [3] = '{0, 3, 2};
  int          emax [3] = '{255, 255, 3};
  int          checks = 0;
  int          failures = 0;

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      ecnt[a] = 0;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 16; c++) mem[a][b][c] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [2:0] s, input logic [31:0] a);
    logic [9:0] word;
    word = a[11:2];
    return ($countones(s) != 1) || (a[1:0] != 2'b00) || (word >= 10'd16);
  endfunction

  function automatic int slv_of(input logic [2:0] s);
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) if (s[i]) k = i;
    return k;
  endfunction

  // Full transfer on instance 'cur': SETUP, then Penable held until completion.
  task automatic xfer(input logic [2:0] sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bit          err;
    int          s, w;
    logic [31:0] exp_rd;
    err    = is_err(sel, addr);
    s      = slv_of(sel);
    w      = int'(addr[5:2]);
    exp_rd = (err || wr) ? 32'h0 : mem[cur][s][w];
    t_sel = sel; t_en = 1'b0; t_wr = wr; t_addr = addr; t_wdata = wdata;
    @(posedge Hclk); #1;
    t_en = 1'b1;
    for (int k = 0; k <= ws[cur]; k++) begin
      @(negedge Hclk);
      chk("pready", 32'(o_ready), 32'(k == ws[cur]));
      chk("pslverr", 32'(o_slverr), 32'((k == ws[cur]) && err));
      chk("prdata", o_rdata, (k == ws[cur]) ? exp_rd : 32'h0);
      @(posedge Hclk); #1;
    end
    t_sel = '0; t_en = 1'b0;
    if (!err && wr) mem[cur][s][w] = wdata;
    if (err && ecnt[cur] < emax[cur]) ecnt[cur]++;
    @(negedge Hclk);
    chk("idle_pready", 32'(o_ready), 32'h0);
    chk("perr_cnt", o_ecnt, 32'(ecnt[cur]));
  endtask

  initial begin
    logic [2:0]  rsel;
    logic [31:0] raddr;
    model_reset();

    #12;
    for (int i = 0; i < 3; i++) begin
      cur = i; #1;
      chk("rst_pready", 32'(o_ready), 32'h0);
      chk("rst_prdata", o_rdata, 32'h0);
      chk("rst_pslverr", 32'(o_slverr), 32'h0);
      chk("rst_errcnt", o_ecnt, 32'h0);
    end
    cur = 0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1;

    // Write/readback on zero-wait instance; other slaves stay empty.
    xfer(3'b010, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    xfer(3'b010, 1'b0, 32'h0000_0008, 32'h0);
    xfer(3'b001, 1'b0, 32'h0000_0008, 32'h0);
    xfer(3'b100, 1'b0, 32'h0000_0008, 32'h0);

    // Wait states.
    cur = 1;
    xfer(3'b001, 1'b0, 32'h0000_0000, 32'h0);
    xfer(3'b100, 1'b1, 32'h0000_003C, 32'hCAFE_0001);
    xfer(3'b100, 1'b0, 32'h0000_003C, 32'h0);

    // Error responses: multi-select, misaligned, out of range.
    cur = 0;
    xfer(3'b011, 1'b1, 32'h0000_0008, 32'h1111_1111);
    xfer(3'b010, 1'b1, 32'h0000_0002, 32'h2222_2222);
    xfer(3'b010, 1'b1, 32'h0000_0040, 32'h3333_3333);
    chk("errcnt_three", o_ecnt, 32'd3);
    xfer(3'b010, 1'b0, 32'h0000_0008, 32'h0);

    // Saturating counter on the 2-bit instance.
    cur = 2;
    for (int i = 0; i < 5; i++) xfer(3'b001, 1'b0, 32'h0000_0001, 32'h0);
    chk("errcnt_sat", o_ecnt, 32'd3);

    // Abort by dropping Pselx mid-ACCESS of a write.
    xfer(3'b001, 1'b1, 32'h0000_0010, 32'h0000_A5A5);
    t_sel = 3'b001; t_en = 1'b0; t_wr = 1'b1; t_addr = 32'h0000_0010; t_wdata = 32'hFFFF_FFFF;
    @(posedge Hclk); #1;
    t_sel = 3'b000; t_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk("abort_pready", 32'(o_ready), 32'h0);
      @(posedge Hclk); #1;
    end
    t_en = 1'b0;
    @(negedge Hclk);
    chk("abort_errcnt", o_ecnt, 32'(ecnt[2]));
    xfer(3'b001, 1'b0, 32'h0000_0010, 32'h0);

    // Penable high while IDLE is ignored.
    cur = 0;
    t_sel = 3'b001; t_en = 1'b1; t_wr = 1'b1; t_addr = 32'h0000_0008; t_wdata = 32'h5555_5555;
    for (int k = 0; k < 2; k++) begin
      @(posedge Hclk); #1;
      @(negedge Hclk);
      chk("idle_en_pready", 32'(o_ready), 32'h0);
    end
    t_sel = '0; t_en = 1'b0;
    xfer(3'b001, 1'b0, 32'h0000_0008, 32'h0);

    // Randomized transfers across all three configurations.
    for (int n = 0; n < 40; n++) begin
      cur = int'($urandom_range(0, 2));
      rsel = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'(1 << $urandom_range(0, 2));
      raddr = {$urandom(), 2'b00};
      raddr[11:2] = 10'($urandom_range(0, 17));
      if ($urandom_range(0, 7) == 0) raddr[1:0] = 2'($urandom_range(1, 3));
      xfer(rsel, 1'($urandom_range(0, 1)), raddr, $urandom());
    end

    // Async reset during a completing read.
    cur = 0;
    xfer(3'b100, 1'b1, 32'h0000_0010, 32'h1234_5678);
    t_sel = 3'b100; t_en = 1'b0; t_wr = 1'b0; t_addr = 32'h0000_0010;
    @(posedge Hclk); #1;
    t_en = 1'b1;
    @(negedge Hclk);
    chk("pre_rst_pready", 32'(o_ready), 32'h1);
    chk("pre_rst_prdata", o_rdata, 32'h1234_5678);
    #2;
    Hresetn = 1'b0;
    #1;
    chk("async_rst_pready", 32'(o_ready), 32'h0);
    chk("async_rst_prdata", o_rdata, 32'h0);
    chk("async_rst_pslverr", 32'(o_slverr), 32'h0);
    chk("async_rst_errcnt", o_ecnt, 32'h0);
    t_sel = '0; t_en = 1'b0;
    model_reset();
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    xfer(3'b100, 1'b0, 32'h0000_0010, 32'h0);
    xfer(3'b010, 1'b0, 32'h0000_0008, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
